// File: rtl/i2c_master_pkg.sv
// Shared constants for the I2C write master: FSM encoding, phase lengths in quarter-bit
// ticks, ACK slot positions within the 27-bit frame, and the retry limit.
package i2c_master_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int unsigned START_QTRS = 2;
    localparam int unsigned BIT_QTRS   = 4;
    localparam int unsigned STOP_QTRS  = 3;

    // Frame positions count up from 0; the bit counter runs LAST_BIT down to 0.
    localparam logic [4:0] LAST_BIT = 5'd26;
    localparam logic [4:0] ACK_POS0 = 5'd8;
    localparam logic [4:0] ACK_POS1 = 5'd17;
    localparam logic [4:0] ACK_POS2 = 5'd26;

    localparam int unsigned MAX_RETRY = 3;

    function automatic logic phase_last(input logic [1:0] qtr, input int unsigned len);
        return qtr == 2'(len - 1);
    endfunction

    function automatic logic is_ack_slot(input logic [4:0] cnt);
        logic [4:0] pos;
        pos = LAST_BIT - cnt;
        return (pos == ACK_POS0) || (pos == ACK_POS1) || (pos == ACK_POS2);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit enable generator: one-cycle pulse every DIV clocks, restartable by a
// synchronous clear so the first quarter of a transaction is always full length.
module i2c_tick_gen #(
    parameter int unsigned DIV = 625
) (
    input  logic CLOCK_50,
    input  logic iRST_N,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Three-byte I2C write master (address+W, sub-address, data) with open-drain SDAT.
// Optional build macro I2C_NACK_RETRY_EN re-runs a NACKed transfer up to MAX_RETRY times.
module i2c_write_master
    import i2c_master_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned I2C_FREQ = 20_000
) (
    input  logic        CLOCK_50,
    input  logic        iRST_N,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oBUSY,
    output logic        oEND,
    output logic        oACK_ERR,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int unsigned QDIV = CLK_FREQ / (4 * I2C_FREQ);

    logic [2:0]  state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic        nack_q, nack_d;
    logic        ack_err_q, ack_err_d;
`ifdef I2C_NACK_RETRY_EN
    logic [23:0] data_q, data_d;
    logic [1:0]  retry_q, retry_d;
`endif

    logic tick;
    logic tick_clear;
    logic scl;
    logic sda_low;

    assign tick_clear = (state_q == ST_IDLE) && iGO;

    i2c_tick_gen #(
        .DIV (QDIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .iRST_N   (iRST_N),
        .clear    (tick_clear),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
`ifdef I2C_NACK_RETRY_EN
        data_d    = data_q;
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iGO) begin
                    state_d   = ST_START;
                    qtr_d     = '0;
                    bit_cnt_d = LAST_BIT;
                    shift_d   = iDATA;
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
`ifdef I2C_NACK_RETRY_EN
                    data_d    = iDATA;
                    retry_d   = '0;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    if (phase_last(qtr_q, START_QTRS)) begin
                        state_d = ST_BIT;
                        qtr_d   = '0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    if (phase_last(qtr_q, BIT_QTRS)) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        state_d   = is_ack_slot(bit_cnt_q - 5'd1) ? ST_ACK : ST_BIT;
                        qtr_d     = '0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        nack_d = I2C_SDAT;
                    end
                    if (phase_last(qtr_q, BIT_QTRS)) begin
                        qtr_d = '0;
                        // A NACK abandons the remaining bits; bit 0 is the final ACK slot.
                        if (nack_q || (bit_cnt_q == 5'd0)) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 5'd1;
                            state_d   = ST_BIT;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (phase_last(qtr_q, STOP_QTRS)) begin
                        qtr_d = '0;
`ifdef I2C_NACK_RETRY_EN
                        if (nack_q && (retry_q != 2'(MAX_RETRY))) begin
                            state_d   = ST_START;
                            retry_d   = retry_q + 2'd1;
                            shift_d   = data_q;
                            bit_cnt_d = LAST_BIT;
                            nack_d    = 1'b0;
                        end else begin
                            state_d   = ST_DONE;
                            ack_err_d = nack_q;
                        end
`else
                        state_d   = ST_DONE;
                        ack_err_d = nack_q;
`endif
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            qtr_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            data_q    <= '0;
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
`ifdef I2C_NACK_RETRY_EN
            data_q    <= data_d;
            retry_q   <= retry_d;
`endif
        end
    end

    // Bus pins decode straight from state so an async reset releases them at once.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            ST_START: sda_low = qtr_q[0];
            ST_BIT: begin
                scl     = qtr_q[1];
                sda_low = ~shift_q[23];
            end
            ST_ACK:  scl = qtr_q[1];
            ST_STOP: begin
                scl     = (qtr_q != 2'd0);
                sda_low = (qtr_q != 2'd2);
            end
            default: begin
                scl     = 1'b1;
                sda_low = 1'b0;
            end
        endcase
    end

    assign I2C_SCLK = scl;
    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
    assign oBUSY    = (state_q != ST_IDLE);
    assign oEND     = (state_q == ST_DONE);
    assign oACK_ERR = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master with a bus-level slave model and a byte scoreboard.
// Expectations for the retry scenarios follow the I2C_NACK_RETRY_EN build macro.
module tb_i2c_write_master;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned I2C_FREQ = 1_250_000;
    localparam int Q       = int'(CLK_FREQ / (4 * I2C_FREQ));
    localparam int FULL_Q  = 113;
    localparam int NACK0_Q = 41;

    logic        CLOCK_50 = 1'b0;
    logic        iRST_N   = 1'b0;
    logic [23:0] iDATA    = '0;
    logic        iGO      = 1'b0;
    logic        oBUSY, oEND, oACK_ERR, I2C_SCLK;
    wire         sda_bus;
    logic        slave_low = 1'b0;

    pullup (sda_bus);
    assign sda_bus = slave_low ? 1'b0 : 1'bz;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int end_count = 0;
    int start_count = 0;
    int nack_byte = -1;
    int nacks_left = 0;
    logic [7:0] exp_q[$];

    i2c_write_master #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .iRST_N   (iRST_N),
        .iDATA    (iDATA),
        .iGO      (iGO),
        .oBUSY    (oBUSY),
        .oEND     (oEND),
        .oACK_ERR (oACK_ERR),
        .I2C_SCLK (I2C_SCLK),
        .I2C_SDAT (sda_bus)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;
    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_bytes(input logic [23:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(d[23 - 8*i -: 8]);
    endtask

    task automatic start_txn(input logic [23:0] d, input bit hold, output int t0);
        @(negedge CLOCK_50);
        iDATA = d;
        iGO   = 1'b1;
        @(negedge CLOCK_50);
        chk("accept_busy", oBUSY, 1);
        chk("accept_ack_err_clear", oACK_ERR, 0);
        t0 = cyc;
        if (!hold) iGO = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget, output int t1);
        int n = 0;
        while (!oEND && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk(tag, oEND, 1);
        t1 = cyc;
    endtask

    // Slave: counts STARTs and oEND pulses, checks each received byte, ACKs unless told not to.
    initial begin
        logic       scl_p, sda_p, scl, sda;
        logic [7:0] rx, exp_b;
        int         bitpos, byte_idx;
        bit         in_txn, nack_now;
        scl_p = 1'b1; sda_p = 1'b1; rx = '0; bitpos = 0; byte_idx = 0;
        in_txn = 1'b0; nack_now = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            scl = I2C_SCLK;
            sda = sda_bus;
            if (oEND) end_count++;
            if (scl && scl_p && sda_p && !sda) begin
                start_count++;
                in_txn = 1'b1; bitpos = 0; byte_idx = 0;
            end else if (scl && scl_p && !sda_p && sda) begin
                in_txn = 1'b0; slave_low = 1'b0;
            end else if (in_txn && scl && !scl_p) begin
                if (bitpos < 8) begin
                    rx = {rx[6:0], sda};
                    bitpos++;
                    if (bitpos == 8) begin
                        chk("byte_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            exp_b = exp_q.pop_front();
                            chk("byte_value", rx, exp_b);
                        end
                        nack_now = (byte_idx == nack_byte) && (nacks_left > 0);
                        if (nack_now) nacks_left--;
                    end
                end else begin
                    bitpos = 0;
                    byte_idx++;
                end
            end else if (in_txn && !scl && scl_p) begin
                slave_low = (bitpos == 8) && !nack_now;
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    initial begin
        int t0, t1, e0, s0;

        repeat (3) @(negedge CLOCK_50);
        chk("rst_busy", oBUSY, 0);
        chk("rst_end", oEND, 0);
        chk("rst_ack_err", oACK_ERR, 0);
        chk("rst_scl", I2C_SCLK, 1);
        chk("rst_sda", sda_bus, 1);
        iRST_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // Full write, all bytes ACKed.
        s0 = start_count;
        push_bytes(24'h340E05, 3);
        start_txn(24'h340E05, 1'b0, t0);
        wait_end("a_end", FULL_Q*Q + 4*Q, t1);
        chk("a_cycles", t1 - t0, FULL_Q*Q);
        chk("a_ack_err", oACK_ERR, 0);
        @(negedge CLOCK_50);
        chk("a_end_one_cycle", oEND, 0);
        chk("a_busy_after", oBUSY, 0);
        chk("a_starts", start_count - s0, 1);
        chk("a_bytes_done", exp_q.size(), 0);

        // Address byte NACKed.
        nack_byte = 0; nacks_left = 100;
        push_bytes(24'hA01122, 1);
        start_txn(24'hA01122, 1'b0, t0);
        wait_end("b_end", FULL_Q*Q, t1);
        chk("b_cycles", t1 - t0, NACK0_Q*Q);
        chk("b_ack_err", oACK_ERR, 1);
        nack_byte = -1; nacks_left = 0;
        @(negedge CLOCK_50);
        chk("b_bytes_done", exp_q.size(), 0);

        // iGO held and iDATA changed mid-transfer; re-accept right after DONE.
        e0 = end_count;
        push_bytes(24'h5AC381, 3);
        start_txn(24'h5AC381, 1'b1, t0);
        iDATA = 24'hFFFFFF;
        wait_end("c_end", FULL_Q*Q + 4*Q, t1);
        chk("c_cycles", t1 - t0, FULL_Q*Q);
        push_bytes(24'hFFFFFF, 3);
        @(negedge CLOCK_50);
        chk("c_idle_gap", oBUSY, 0);
        chk("c_one_end", end_count - e0, 1);
        @(negedge CLOCK_50);
        chk("c_reaccept", oBUSY, 1);
        t0 = cyc;
        iGO = 1'b0;
        wait_end("c2_end", FULL_Q*Q + 4*Q, t1);
        chk("c2_cycles", t1 - t0, FULL_Q*Q);
        chk("c2_ack_err", oACK_ERR, 0);
        @(negedge CLOCK_50);
        chk("c_bytes_done", exp_q.size(), 0);

        // Asynchronous reset mid-transfer (bit 11, SCLK high, SDAT low).
        e0 = end_count;
        push_bytes(24'h340E05, 3);
        start_txn(24'h340E05, 1'b0, t0);
        repeat (48*Q) @(negedge CLOCK_50);
        chk("d_busy_pre", oBUSY, 1);
        chk("d_sda_pre", sda_bus, 0);
        #3 iRST_N = 1'b0;
        #1;
        chk("d_scl", I2C_SCLK, 1);
        chk("d_sda", sda_bus, 1);
        chk("d_busy", oBUSY, 0);
        chk("d_end", oEND, 0);
        exp_q.delete();
        repeat (3) @(negedge CLOCK_50);
        iRST_N = 1'b1;
        repeat (20*Q) @(negedge CLOCK_50);
        chk("d_no_end", end_count - e0, 0);
        chk("d_busy_post", oBUSY, 0);

        // Address NACKed twice, then ACKed.
        s0 = start_count;
        nack_byte = 0; nacks_left = 2;
`ifdef I2C_NACK_RETRY_EN
        push_bytes(24'h340E05, 1);
        push_bytes(24'h340E05, 1);
        push_bytes(24'h340E05, 3);
        start_txn(24'h340E05, 1'b0, t0);
        wait_end("e_end", (2*NACK0_Q + FULL_Q)*Q + 4*Q, t1);
        chk("e_cycles", t1 - t0, (2*NACK0_Q + FULL_Q)*Q);
        chk("e_ack_err", oACK_ERR, 0);
        chk("e_starts", start_count - s0, 3);
`else
        push_bytes(24'h340E05, 1);
        start_txn(24'h340E05, 1'b0, t0);
        wait_end("e_end", FULL_Q*Q, t1);
        chk("e_cycles", t1 - t0, NACK0_Q*Q);
        chk("e_ack_err", oACK_ERR, 1);
        chk("e_starts", start_count - s0, 1);
`endif
        nack_byte = -1; nacks_left = 0;
        @(negedge CLOCK_50);
        chk("e_bytes_done", exp_q.size(), 0);

        // Data byte NACKed on every attempt.
        s0 = start_count;
        nack_byte = 2; nacks_left = 100;
`ifdef I2C_NACK_RETRY_EN
        for (int i = 0; i < 4; i++) push_bytes(24'h1234C7, 3);
        start_txn(24'h1234C7, 1'b0, t0);
        wait_end("f_end", 4*FULL_Q*Q + 4*Q, t1);
        chk("f_cycles", t1 - t0, 4*FULL_Q*Q);
        chk("f_starts", start_count - s0, 4);
`else
        push_bytes(24'h1234C7, 3);
        start_txn(24'h1234C7, 1'b0, t0);
        wait_end("f_end", FULL_Q*Q + 4*Q, t1);
        chk("f_cycles", t1 - t0, FULL_Q*Q);
        chk("f_starts", start_count - s0, 1);
`endif
        chk("f_ack_err", oACK_ERR, 1);
        nack_byte = -1; nacks_left = 0;
        @(negedge CLOCK_50);
        chk("f_bytes_done", exp_q.size(), 0);
        chk("total_ends", end_count, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
REQ-001 CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 I2C_FREQ, 20000, SCLK bit rate in Hz; quarter-bit tick period Q = CLK_FREQ/(4*I2C_FREQ) = 625 cycles.
REQ-003 CLOCK_50  input  1  system clock; all logic on rising edge.
REQ-004 iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 iDATA  input  24  {slave_addr+W, sub_addr, data}, transmitted MSB first.
REQ-006 iGO  input  1  start request; level, sampled each cycle.
REQ-007 oBUSY  output  1  high from accept cycle to oEND cycle inclusive.
REQ-008 oEND  output  1  one-cycle pulse at transaction completion.
REQ-009 oACK_ERR  output  1  NACK status of last transaction; valid from oEND until next accept.
REQ-010 I2C_SCLK  output  1  I2C clock; idle high.
REQ-011 I2C_SDAT  inout  1  I2C data; open-drain: drive 0 or Z only.

Function
REQ-012 Accept: iGO=1 and oBUSY=0 -> latch iDATA, clear oACK_ERR, clear tick counter, oBUSY=1 next cycle.
REQ-013 iGO while oBUSY=1 is ignored; iDATA changes after accept have no effect.
REQ-014 States: IDLE, START, BIT, ACK, STOP, DONE; all transitions occur only on a quarter tick, except DONE, which lasts exactly one cycle.
REQ-015 START: 2 quarters; SDAT released Q0, SDAT low Q1, SCLK high both quarters.
REQ-016 BIT: 4 quarters per bit; SCLK low Q0-Q1, high Q2-Q3; SDAT changes only at Q0 start.
REQ-017 ACK slot after each byte (bits 8, 17, 26): SDAT released; line sampled at end of Q2; 1 = NACK.
REQ-018 NACK -> set oACK_ERR, skip remaining bits, go to STOP.
REQ-019 STOP: 3 quarters; SCLK low/SDAT low, SCLK high/SDAT low, SCLK high/SDAT released.
REQ-020 DONE: oEND=1, oBUSY=0 next cycle, return to IDLE; new iGO is accepted the cycle after DONE.
REQ-021 Full transaction with no NACK = 2+27*4+3 = 113 quarters; oEND exactly 113*625 = 70625 cycles after the accept cycle.
REQ-022 Bit counter 5 bits, counts 26 down to 0; no wrap past 0.

Reset
REQ-023 Reset values: state IDLE, oBUSY=0, oEND=0, oACK_ERR=0, I2C_SCLK=1, I2C_SDAT=Z, counters 0.
REQ-024 Reset mid-transaction releases the bus immediately, asynchronously; no STOP is generated and no oEND is issued.

Configuration
REQ-025 Macro I2C_NACK_RETRY_EN defined: after a NACK STOP, restart from START with the same latched data, up to 3 retries; oBUSY stays high; oACK_ERR=1 only if the 4th attempt NACKs; oEND issued once.
REQ-026 I2C_NACK_RETRY_EN undefined: single attempt per REQ-018; retry counter absent.

Structure
REQ-027 Package i2c_master_pkg holds the state enum, the phase constants (START=2, BIT=4, STOP=3 quarters), the ACK bit positions and MAX_RETRY=3.
REQ-028 Sub-module i2c_tick_gen: parameterised divider emitting a one-cycle quarter-bit enable, with synchronous clear on accept.

Verification
REQ-029 Scenarios:
- iDATA=24'h34_0E_05, slave ACKs all bytes -> SDAT bit sequence 00110100, 00001110, 00000101; oEND at +70625 cycles; oACK_ERR=0.
- Slave NACKs the address byte -> STOP after bit 8 ACK slot; oEND at +(2+36+3)*625 = 25625 cycles; oACK_ERR=1.
- iGO held high during a transaction with iDATA changed to 24'hFFFFFF -> original data sent; exactly one oEND; next accept the cycle after DONE.
- iRST_N low at +30000 cycles -> same cycle SCLK=1, SDAT=Z, oBUSY=0; no oEND pulse.
- Retry macro defined, slave NACKs twice then ACKs -> 3 START conditions, oACK_ERR=0, one oEND.
- Retry macro defined, persistent NACK on data byte -> 4 attempts, oACK_ERR=1; with the macro undefined, 1 attempt.
